// File: rtl/gb_square_channel.sv
// gb_square_channel
// Game Boy style square-wave voice: 11-bit frequency timer driving an
// 8-step duty sequencer, 6-bit length counter, 4-bit volume envelope and,
// when the macro SQ_SWEEP_EN is defined, a frequency-sweep unit (voice 1).
// Without SQ_SWEEP_EN the sweep inputs are ignored and the timer follows
// the live frequency input (voice 2).
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   i_clk256/128/64 frame-sequencer square waves (edge detected here)
//   i_swpPd        sweep period (0 means 8 for the timer, disables sweeping)
//   i_negate       sweep direction, 1 = subtract
//   i_shift        sweep shift amount
//   i_freq         11-bit frequency value f
//   i_lenLoad      length load, counter starts at 64 - i_lenLoad
//   i_duty         duty pattern select
//   i_startVol     envelope initial volume
//   i_period       envelope period, 0 freezes the envelope
//   i_lenEnable    length counter enable
//   i_trigger      level input, rising edge restarts the voice
//   i_envAdd       envelope direction, 1 = increase
//   o_out          registered 4-bit sample
module gb_square_channel (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clk256,
  input  logic        i_clk128,
  input  logic        i_clk64,
  input  logic [2:0]  i_swpPd,
  input  logic        i_negate,
  input  logic [2:0]  i_shift,
  input  logic [10:0] i_freq,
  input  logic [5:0]  i_lenLoad,
  input  logic [1:0]  i_duty,
  input  logic [3:0]  i_startVol,
  input  logic [2:0]  i_period,
  input  logic        i_lenEnable,
  input  logic        i_trigger,
  input  logic        i_envAdd,
  output logic [3:0]  o_out
);

  // Timer reload for one duty step: (2048 - f) * 4, range 4..8192.
  function automatic logic [13:0] periodOf(input logic [10:0] f);
    logic [11:0] d;
    d = 12'd2048 - {1'b0, f};
    return {d, 2'b00};
  endfunction

  logic        r_trigPrev, r_c256Prev, r_c64Prev;
  logic        r_enabled;
  logic [6:0]  r_length;
  logic [3:0]  r_volume;
  logic [2:0]  r_envTimer;
  logic [13:0] r_freqTimer;
  logic [2:0]  r_step;
  logic [3:0]  r_out;

  logic        w_trigEv, w_ev256, w_ev64, w_dacOn, w_patBit, w_trigOverflow;
  logic [10:0] w_freqSrc;
  logic [7:0]  w_pattern;
  logic [2:0]  w_stepIdx;

  assign w_trigEv = i_trigger & ~r_trigPrev;
  assign w_ev256  = i_clk256 & ~r_c256Prev;
  assign w_ev64   = i_clk64 & ~r_c64Prev;
  assign w_dacOn  = (i_startVol != 4'd0) | i_envAdd;

`ifdef SQ_SWEEP_EN
  // Sweep step: shadow +/- (shadow >> shift); bit 11 set means above 2047.
  function automatic logic [11:0] sweepCalc(input logic [10:0] s, input logic neg,
                                            input logic [2:0] sh);
    logic [11:0] base;
    logic [11:0] delta;
    base  = {1'b0, s};
    delta = base >> sh;
    return neg ? (base - delta) : (base + delta);
  endfunction

  logic        r_c128Prev;
  logic [10:0] r_shadow;
  logic [3:0]  r_sweepTimer;
  logic        r_sweepEn;
  logic        w_ev128;
  logic [3:0]  w_swpReload;
  logic [11:0] w_trigCalc, w_sweepNew, w_sweepCheck;

  assign w_ev128        = i_clk128 & ~r_c128Prev;
  assign w_swpReload    = (i_swpPd == 3'd0) ? 4'd8 : {1'b0, i_swpPd};
  assign w_trigCalc     = sweepCalc(i_freq, i_negate, i_shift);
  assign w_trigOverflow = (i_shift != 3'd0) && w_trigCalc[11];
  assign w_sweepNew     = sweepCalc(r_shadow, i_negate, i_shift);
  assign w_sweepCheck   = sweepCalc(w_sweepNew[10:0], i_negate, i_shift);
  assign w_freqSrc      = r_shadow;

  // Sweep state: trigger loads the shadow; clk128 events step the sweep timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c128Prev   <= 1'b0;
      r_shadow     <= 11'd0;
      r_sweepTimer <= 4'd0;
      r_sweepEn    <= 1'b0;
    end else begin
      r_c128Prev <= i_clk128;
      if (w_trigEv) begin
        r_shadow     <= i_freq;
        r_sweepTimer <= w_swpReload;
        r_sweepEn    <= (i_swpPd != 3'd0) || (i_shift != 3'd0);
      end else if (w_ev128) begin
        if (r_sweepTimer <= 4'd1) begin
          r_sweepTimer <= w_swpReload;
          if (r_sweepEn && (i_swpPd != 3'd0) && !w_sweepNew[11] && (i_shift != 3'd0))
            r_shadow <= w_sweepNew[10:0];
        end else begin
          r_sweepTimer <= r_sweepTimer - 4'd1;
        end
      end
    end
  end

  // Sweep overflow (first result or the follow-up check) silences the voice.
  logic w_sweepKill;
  assign w_sweepKill = !w_trigEv && w_ev128 && (r_sweepTimer <= 4'd1) && r_sweepEn &&
                       (i_swpPd != 3'd0) &&
                       (w_sweepNew[11] || ((i_shift != 3'd0) && w_sweepCheck[11]));
`else
  logic w_unused;
  assign w_unused       = ^{i_clk128, i_swpPd, i_negate, i_shift};
  assign w_trigOverflow = 1'b0;
  assign w_freqSrc      = i_freq;
  logic w_sweepKill;
  assign w_sweepKill    = 1'b0;
`endif

  // Duty pattern lookup; step 0 is the leftmost bit of each pattern.
  always_comb begin
    w_pattern = 8'b00000001;
    case (i_duty)
      2'd0: w_pattern = 8'b00000001;
      2'd1: w_pattern = 8'b10000001;
      2'd2: w_pattern = 8'b10000111;
      2'd3: w_pattern = 8'b01111110;
      default: w_pattern = 8'b00000001;
    endcase
    w_stepIdx = 3'd7 - r_step;
    w_patBit  = w_pattern[w_stepIdx];
  end

  // Voice state. A trigger takes priority and drops any frame event in the
  // same cycle; later assignments to r_enabled override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trigPrev  <= 1'b0;
      r_c256Prev  <= 1'b0;
      r_c64Prev   <= 1'b0;
      r_enabled   <= 1'b0;
      r_length    <= 7'd0;
      r_volume    <= 4'd0;
      r_envTimer  <= 3'd0;
      r_freqTimer <= 14'd0;
      r_step      <= 3'd0;
    end else begin
      r_trigPrev <= i_trigger;
      r_c256Prev <= i_clk256;
      r_c64Prev  <= i_clk64;
      if (w_trigEv) begin
        r_enabled   <= w_dacOn && !w_trigOverflow;
        r_length    <= 7'd64 - {1'b0, i_lenLoad};
        r_volume    <= i_startVol;
        r_envTimer  <= i_period;
        r_freqTimer <= periodOf(i_freq);
        r_step      <= 3'd0;
      end else begin
        // A timer of 0 only occurs before the first trigger and stays idle.
        if (r_freqTimer == 14'd1) begin
          r_freqTimer <= periodOf(w_freqSrc);
          r_step      <= r_step + 3'd1;
        end else if (r_freqTimer != 14'd0) begin
          r_freqTimer <= r_freqTimer - 14'd1;
        end
        if (w_ev256 && i_lenEnable && (r_length != 7'd0)) begin
          r_length <= r_length - 7'd1;
          if (r_length == 7'd1)
            r_enabled <= 1'b0;
        end
        if (w_ev64 && (i_period != 3'd0)) begin
          if (r_envTimer <= 3'd1) begin
            r_envTimer <= i_period;
            if (i_envAdd && (r_volume != 4'd15))
              r_volume <= r_volume + 4'd1;
            else if (!i_envAdd && (r_volume != 4'd0))
              r_volume <= r_volume - 4'd1;
          end else begin
            r_envTimer <= r_envTimer - 3'd1;
          end
        end
        if (w_sweepKill)
          r_enabled <= 1'b0;
        if (!w_dacOn)
          r_enabled <= 1'b0;
      end
    end
  end

  // Output register: one cycle behind the state it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_out <= 4'd0;
    else
      r_out <= (r_enabled && w_patBit) ? r_volume : 4'd0;
  end

  assign o_out = r_out;

endmodule

// File: tb/tb_gb_square_channel.sv
// tb_gb_square_channel
// Directed testbench for gb_square_channel: reset, duty/frequency timing,
// length counter, envelope, DAC gating and (with SQ_SWEEP_EN) the sweep unit.
// Inputs change 1 time unit after a rising edge; o_out is checked there too.
module tb_gb_square_channel;

  logic        clk;
  logic        rst_n;
  logic        i_clk256, i_clk128, i_clk64;
  logic [2:0]  i_swpPd;
  logic        i_negate;
  logic [2:0]  i_shift;
  logic [10:0] i_freq;
  logic [5:0]  i_lenLoad;
  logic [1:0]  i_duty;
  logic [3:0]  i_startVol;
  logic [2:0]  i_period;
  logic        i_lenEnable;
  logic        i_trigger;
  logic        i_envAdd;
  logic [3:0]  o_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trigCyc = 0;
  int expVol = 0;

  gb_square_channel dut (
    .clk(clk), .rst_n(rst_n),
    .i_clk256(i_clk256), .i_clk128(i_clk128), .i_clk64(i_clk64),
    .i_swpPd(i_swpPd), .i_negate(i_negate), .i_shift(i_shift),
    .i_freq(i_freq), .i_lenLoad(i_lenLoad), .i_duty(i_duty),
    .i_startVol(i_startVol), .i_period(i_period), .i_lenEnable(i_lenEnable),
    .i_trigger(i_trigger), .i_envAdd(i_envAdd), .o_out(o_out)
  );

  // Free-running clock and rising-edge counter used to time expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance to 1 time unit after rising edge number n.
  task automatic stepTo(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    stepTo(cyc + n);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    checks++;
    assert (o_out === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, o_out, expected);
    end
  endtask

  // Raise trigger and remember the edge count just before it is sampled.
  task automatic applyStimulus();
    i_trigger = 1'b1;
    trigCyc   = cyc;
  endtask

  // One frame-sequencer pulse: 0 = clk256, 1 = clk128, 2 = clk64.
  task automatic pulseFrame(input int which);
    case (which)
      0: i_clk256 = 1'b1;
      1: i_clk128 = 1'b1;
      default: i_clk64 = 1'b1;
    endcase
    step(2);
    i_clk256 = 1'b0;
    i_clk128 = 1'b0;
    i_clk64  = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n = 1'b0;
    i_clk256 = 1'b0; i_clk128 = 1'b0; i_clk64 = 1'b0;
    i_swpPd = 3'd3; i_negate = 1'b0; i_shift = 3'd2;
    i_freq = 11'd1792; i_lenLoad = 6'd5; i_duty = 2'd2;
    i_startVol = 4'd15; i_period = 3'd0; i_lenEnable = 1'b0;
    i_trigger = 1'b0; i_envAdd = 1'b0;

    // Reset and idle behaviour.
    #23;
    checkOutput("reset", 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(20);
    checkOutput("idle_no_trigger", 4'd0);

    // Duty 2 at f = 1792: step length 1024 cycles, period 8192.
    i_swpPd = 3'd0; i_shift = 3'd0;
    applyStimulus();
    stepTo(trigCyc + 1);
    checkOutput("trig_latency_1", 4'd0);
    stepTo(trigCyc + 2);
    checkOutput("trig_latency_2", 4'd15);
    i_trigger = 1'b0;
    stepTo(trigCyc + 1 + 1024);
    checkOutput("step0_last", 4'd15);
    stepTo(trigCyc + 2 + 1024);
    checkOutput("step1_first", 4'd0);
    stepTo(trigCyc + 1 + 5120);
    checkOutput("step4_last", 4'd0);
    stepTo(trigCyc + 2 + 5120);
    checkOutput("step5_first", 4'd15);
    stepTo(trigCyc + 1 + 9216);
    checkOutput("period2_step0_last", 4'd15);
    stepTo(trigCyc + 2 + 9216);
    checkOutput("period2_step1_first", 4'd0);
    i_duty = 2'd3;
    step(1);
    checkOutput("duty_live_change", 4'd15);

    // Asynchronous reset while sounding.
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset", 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3);
    checkOutput("after_reset_silent", 4'd0);

    // Length: 64 - 62 = 2 ticks; f = 0 keeps step 0 for 8192 cycles.
    i_freq = 11'd0; i_duty = 2'd2; i_lenLoad = 6'd62; i_lenEnable = 1'b1;
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("len_start", 4'd15);
    i_trigger = 1'b0;
    pulseFrame(0);
    checkOutput("len_after_1", 4'd15);
    pulseFrame(0);
    checkOutput("len_after_2", 4'd0);

    // Trigger coinciding with a clk256 edge: the length tick is dropped.
    i_lenLoad = 6'd63;
    applyStimulus();
    i_clk256 = 1'b1;
    stepTo(trigCyc + 2);
    i_trigger = 1'b0;
    i_clk256 = 1'b0;
    step(2);
    checkOutput("trigger_beats_frame", 4'd15);
    pulseFrame(0);
    checkOutput("len_63_expired", 4'd0);

    // Envelope up from 8 with period 1, then down to 0.
    i_lenEnable = 1'b0; i_startVol = 4'd8; i_envAdd = 1'b1; i_period = 3'd1;
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("env_start", 4'd8);
    i_trigger = 1'b0;
    expVol = 8;
    for (int i = 0; i < 9; i++) begin
      pulseFrame(2);
      if (expVol < 15) expVol++;
      checkOutput($sformatf("env_up_%0d", i), expVol[3:0]);
    end
    i_envAdd = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pulseFrame(2);
      if (expVol > 0) expVol--;
      checkOutput($sformatf("env_down_%0d", i), expVol[3:0]);
    end

    // DAC off at trigger keeps the voice disabled even if volume rises later.
    i_startVol = 4'd0; i_envAdd = 1'b0; i_period = 3'd1;
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("dac_off_trigger", 4'd0);
    i_trigger = 1'b0;
    i_envAdd = 1'b1;
    pulseFrame(2);
    checkOutput("dac_off_stays_disabled", 4'd0);
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("dac_on_vol0", 4'd0);
    i_trigger = 1'b0;
    pulseFrame(2);
    checkOutput("dac_on_vol1", 4'd1);

    i_startVol = 4'd15; i_envAdd = 1'b0; i_period = 3'd0; i_duty = 2'd2;
    i_freq = 11'd1024; i_swpPd = 3'd1; i_shift = 3'd1; i_negate = 1'b0;
`ifdef SQ_SWEEP_EN
    // Upward sweep: 1024 -> 1536, follow-up check 2304 overflows.
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("sweep_up_start", 4'd15);
    i_trigger = 1'b0;
    pulseFrame(1);
    checkOutput("sweep_up_overflow", 4'd0);

    // Downward sweep: 1024 -> 512 -> 256; later steps last (2048-256)*4.
    i_negate = 1'b1;
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("sweep_down_start", 4'd15);
    i_trigger = 1'b0;
    pulseFrame(1);
    checkOutput("sweep_down_1", 4'd15);
    pulseFrame(1);
    checkOutput("sweep_down_2", 4'd15);
    stepTo(trigCyc + 1 + 4096 + 4 * 7168);
    checkOutput("sweep_step4_last", 4'd0);
    stepTo(trigCyc + 2 + 4096 + 4 * 7168);
    checkOutput("sweep_step5_first", 4'd15);
`else
    // Without the sweep unit clk128 and the sweep inputs have no effect.
    applyStimulus();
    stepTo(trigCyc + 2);
    checkOutput("nosweep_start", 4'd15);
    i_trigger = 1'b0;
    pulseFrame(1);
    checkOutput("nosweep_clk128", 4'd15);
    stepTo(trigCyc + 1 + 4096);
    checkOutput("nosweep_step0_last", 4'd15);
    stepTo(trigCyc + 2 + 4096);
    checkOutput("nosweep_step1_first", 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
